uart_recv_bytes: RTL and testbench

UART_RECV_BYTES -- requirements
Module: uart_recv_bytes

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_recv_bytes.sv | 108 ++++++++++
 tb/tb_uart_recv_bytes.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and default framing parameters
// used by both the byte-assembling receiver and the sender.
package uart_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } uart_state_e;

    localparam int DEF_BYTES_NUM   = 4;
    localparam int DEF_TIMEOUT_CYC = 50000;

    // Keeps only the low 'bytes' bytes of a 32-bit word.
    function automatic logic [31:0] word_mask(input int bytes);
        logic [31:0] m;
        if (bytes >= 4)
            m = 32'hFFFF_FFFF;
        else
            m = (32'd1 << (8 * bytes)) - 32'd1;
        return m;
    endfunction

endpackage

// File: rtl/uart_recv_bytes.sv
// Assembles BYTES_NUM consecutive UART bytes into one word, first byte most
// significant; a stalled partial word is dropped after TIMEOUT_CYC idle cycles.
module uart_recv_bytes
    import uart_pkg::*;
#(
    parameter int BYTES_NUM   = DEF_BYTES_NUM,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        uart_done,
    input  logic [7:0]  uart_data,
    output logic        word_valid,
    output logic [31:0] word_data,
    output logic        bytes_busy,
    output logic        timeout_err
);

    localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [2:0]       LAST_IDX = 3'(BYTES_NUM - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYC);
    localparam logic [31:0]      USED_MSK = word_mask(BYTES_NUM);

    logic              done_d0;
    logic              done_d1;
    logic [7:0]        rx_byte;
    logic              byte_evt;
    uart_state_e       state;
    logic [31:0]       shift_reg;
    logic [31:0]       shift_next;
    logic [2:0]        byte_cnt;
    logic [TMO_W-1:0]  tmo_cnt;

    // uart_done may be held for several cycles; only its rising edge counts.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            done_d0 <= 1'b0;
            done_d1 <= 1'b0;
            rx_byte <= 8'd0;
        end else begin
            done_d0 <= uart_done;
            done_d1 <= done_d0;
            if (uart_done && !done_d0)
                rx_byte <= uart_data;
        end
    end

    assign byte_evt   = done_d0 & ~done_d1;
    assign shift_next = {shift_reg[23:0], rx_byte};

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= ST_IDLE;
            shift_reg   <= 32'd0;
            byte_cnt    <= 3'd0;
            tmo_cnt     <= '0;
            word_valid  <= 1'b0;
            word_data   <= 32'd0;
            bytes_busy  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            word_valid  <= 1'b0;
            timeout_err <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    tmo_cnt <= '0;
                    if (byte_evt) begin
                        shift_reg  <= shift_next;
                        byte_cnt   <= 3'd1;
                        state      <= ST_RECV;
                        bytes_busy <= 1'b1;
                    end
                end
                ST_RECV: begin
                    // A byte arriving on the terminal count beats the timeout.
                    if (byte_evt) begin
                        shift_reg <= shift_next;
                        tmo_cnt   <= '0;
                        if (byte_cnt == LAST_IDX) begin
                            word_data  <= shift_next & USED_MSK;
                            word_valid <= 1'b1;
                            byte_cnt   <= 3'd0;
                            state      <= ST_IDLE;
                            bytes_busy <= 1'b0;
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        timeout_err <= 1'b1;
                        shift_reg   <= 32'd0;
                        byte_cnt    <= 3'd0;
                        tmo_cnt     <= '0;
                        state       <= ST_IDLE;
                        bytes_busy  <= 1'b0;
                    end else if (tmo_cnt != TMO_MAX) begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    bytes_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_recv_bytes.sv
// Directed bench for uart_recv_bytes: a default 4-byte instance plus a
// 2-byte instance with a short timeout for the boundary cases.
module tb_uart_recv_bytes;

    localparam int T2 = 64;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        uart_done;
    logic [7:0]  uart_data;
    logic        word_valid;
    logic [31:0] word_data;
    logic        bytes_busy;
    logic        timeout_err;

    logic        done2;
    logic [7:0]  data2;
    logic        wv2;
    logic [31:0] wd2;
    logic        busy2;
    logic        te2;

    int checks   = 0;
    int failures = 0;
    int wv_cnt   = 0;
    int te_cnt   = 0;
    int wv2_cnt  = 0;
    int te2_cnt  = 0;

    uart_recv_bytes dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .uart_done   (uart_done),
        .uart_data   (uart_data),
        .word_valid  (word_valid),
        .word_data   (word_data),
        .bytes_busy  (bytes_busy),
        .timeout_err (timeout_err)
    );

    uart_recv_bytes #(.BYTES_NUM(2), .TIMEOUT_CYC(T2)) dut2 (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .uart_done   (done2),
        .uart_data   (data2),
        .word_valid  (wv2),
        .word_data   (wd2),
        .bytes_busy  (busy2),
        .timeout_err (te2)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (word_valid)  wv_cnt  <= wv_cnt + 1;
        if (timeout_err) te_cnt  <= te_cnt + 1;
        if (wv2)         wv2_cnt <= wv2_cnt + 1;
        if (te2)         te2_cnt <= te2_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; uart_done is high for 'hold' rising edges.
    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        uart_done = 1'b1;
        uart_data = b;
        repeat (hold) @(negedge sys_clk);
        uart_done = 1'b0;
        repeat (gap) @(negedge sys_clk);
    endtask

    task automatic send_byte2(input logic [7:0] b, input int gap);
        done2 = 1'b1;
        data2 = b;
        @(negedge sys_clk);
        done2 = 1'b0;
        repeat (gap) @(negedge sys_clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int hold, input int gap);
        for (int i = 3; i >= 0; i--)
            send_byte(w[8*i +: 8], hold, (i == 0) ? 1 : gap);
    endtask

    task automatic test_reset;
        sys_rst_n = 1'b0;
        uart_done = 1'b0;
        uart_data = 8'h00;
        done2     = 1'b0;
        data2     = 8'h00;
        repeat (3) @(negedge sys_clk);
        checks++;
        if (word_valid !== 1'b0 || timeout_err !== 1'b0 || bytes_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: got wv=%b te=%b busy=%b want 0 0 0", word_valid, timeout_err, bytes_busy);
        end
        checks++;
        if (word_data !== 32'h0 || wd2 !== 32'h0 || busy2 !== 1'b0) begin
            failures++;
            $display("FAIL reset_data: got wd=%h wd2=%h busy2=%b want 0", word_data, wd2, busy2);
        end
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic test_basic_word;
        int wv0;
        wv0 = wv_cnt;
        send_byte(8'h12, 1, 99);
        send_byte(8'h34, 1, 99);
        send_byte(8'h56, 1, 99);
        checks++;
        if (bytes_busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy_mid: got %b want 1", bytes_busy);
        end
        send_byte(8'h78, 1, 1);
        checks++;
        if (word_valid !== 1'b1 || word_data !== 32'h12345678 || bytes_busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_word: got wv=%b wd=%h busy=%b want 1 12345678 0", word_valid, word_data, bytes_busy);
        end
        @(negedge sys_clk);
        checks++;
        if (word_valid !== 1'b0 || wv_cnt - wv0 !== 1) begin
            failures++;
            $display("FAIL basic_single_pulse: got wv=%b pulses=%0d want 0 1", word_valid, wv_cnt - wv0);
        end
        repeat (10) @(negedge sys_clk);
    endtask

    task automatic test_timeout;
        int te0;
        te0 = te_cnt;
        send_byte(8'hDE, 1, 99);
        send_byte(8'hAD, 1, 1);
        repeat (49999) @(negedge sys_clk);
        checks++;
        if (timeout_err !== 1'b0 || bytes_busy !== 1'b1) begin
            failures++;
            $display("FAIL timeout_early: got te=%b busy=%b want 0 1", timeout_err, bytes_busy);
        end
        @(negedge sys_clk);
        checks++;
        if (timeout_err !== 1'b1 || bytes_busy !== 1'b0 || word_data !== 32'h12345678) begin
            failures++;
            $display("FAIL timeout_fire: got te=%b busy=%b wd=%h want 1 0 12345678", timeout_err, bytes_busy, word_data);
        end
        @(negedge sys_clk);
        checks++;
        if (timeout_err !== 1'b0 || te_cnt - te0 !== 1) begin
            failures++;
            $display("FAIL timeout_single_pulse: got te=%b pulses=%0d want 0 1", timeout_err, te_cnt - te0);
        end
        send_word(32'hCAFEBABE, 1, 20);
        checks++;
        if (word_valid !== 1'b1 || word_data !== 32'hCAFEBABE) begin
            failures++;
            $display("FAIL timeout_recover: got wv=%b wd=%h want 1 cafebabe", word_valid, word_data);
        end
        repeat (5) @(negedge sys_clk);
    endtask

    task automatic test_held_done;
        int wv0;
        int te0;
        wv0 = wv_cnt;
        te0 = te_cnt;
        send_word(32'h01020304, 5, 10);
        repeat (5) @(negedge sys_clk);
        checks++;
        if (word_data !== 32'h01020304 || wv_cnt - wv0 !== 1 || te_cnt != te0) begin
            failures++;
            $display("FAIL held_done: got wd=%h pulses=%0d te=%0d want 01020304 1 0", word_data, wv_cnt - wv0, te_cnt - te0);
        end
    endtask

    task automatic test_mid_word_reset;
        int wv0;
        int te0;
        send_byte(8'h11, 1, 10);
        send_byte(8'h22, 1, 10);
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if (bytes_busy !== 1'b0 || word_data !== 32'h0) begin
            failures++;
            $display("FAIL async_reset: got busy=%b wd=%h want 0 0", bytes_busy, word_data);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        wv0 = wv_cnt;
        te0 = te_cnt;
        send_word(32'hAABBCCDD, 1, 10);
        checks++;
        if (word_valid !== 1'b1 || word_data !== 32'hAABBCCDD) begin
            failures++;
            $display("FAIL reset_restart: got wv=%b wd=%h want 1 aabbccdd", word_valid, word_data);
        end
        repeat (3) @(negedge sys_clk);
        checks++;
        if (wv_cnt - wv0 !== 1 || te_cnt != te0) begin
            failures++;
            $display("FAIL reset_restart_counts: got wv=%0d te=%0d want 1 0", wv_cnt - wv0, te_cnt - te0);
        end
    endtask

    task automatic test_done_at_release;
        int wv0;
        sys_rst_n = 1'b0;
        uart_done = 1'b1;
        uart_data = 8'h99;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        wv0 = wv_cnt;
        repeat (4) @(negedge sys_clk);
        uart_done = 1'b0;
        repeat (5) @(negedge sys_clk);
        send_byte(8'hAA, 1, 5);
        send_byte(8'hBB, 1, 5);
        send_byte(8'hCC, 1, 1);
        checks++;
        if (word_valid !== 1'b1 || word_data !== 32'h99AABBCC || wv_cnt - wv0 !== 0) begin
            failures++;
            $display("FAIL done_at_release: got wv=%b wd=%h prior=%0d want 1 99aabbcc 0", word_valid, word_data, wv_cnt - wv0);
        end
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic test_back_to_back;
        int wv0;
        wv0 = wv_cnt;
        send_word(32'h0BADF00D, 1, 1);
        checks++;
        if (word_valid !== 1'b1 || word_data !== 32'h0BADF00D) begin
            failures++;
            $display("FAIL b2b_first: got wv=%b wd=%h want 1 0badf00d", word_valid, word_data);
        end
        send_word(32'hFEEDC0DE, 1, 1);
        checks++;
        if (word_valid !== 1'b1 || word_data !== 32'hFEEDC0DE) begin
            failures++;
            $display("FAIL b2b_second: got wv=%b wd=%h want 1 feedc0de", word_valid, word_data);
        end
        repeat (3) @(negedge sys_clk);
        checks++;
        if (wv_cnt - wv0 !== 2) begin
            failures++;
            $display("FAIL b2b_count: got %0d want 2", wv_cnt - wv0);
        end
    endtask

    task automatic test_two_byte_word;
        int wv0;
        wv0 = wv2_cnt;
        send_byte2(8'h5A, 9);
        send_byte2(8'hC3, 1);
        checks++;
        if (wv2 !== 1'b1 || wd2 !== 32'h00005AC3 || busy2 !== 1'b0) begin
            failures++;
            $display("FAIL two_byte_word: got wv=%b wd=%h busy=%b want 1 00005ac3 0", wv2, wd2, busy2);
        end
        @(negedge sys_clk);
        checks++;
        if (wv2 !== 1'b0 || wv2_cnt - wv0 !== 1) begin
            failures++;
            $display("FAIL two_byte_pulse: got wv=%b pulses=%0d want 0 1", wv2, wv2_cnt - wv0);
        end
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic test_timeout_boundary;
        int te0;
        te0 = te2_cnt;
        send_byte2(8'h11, T2 - 1);
        send_byte2(8'h22, 1);
        checks++;
        if (wv2 !== 1'b1 || te2 !== 1'b0 || wd2 !== 32'h00001122 || te2_cnt != te0) begin
            failures++;
            $display("FAIL tmo_tie_byte_wins: got wv=%b te=%b wd=%h tes=%0d want 1 0 00001122 0", wv2, te2, wd2, te2_cnt - te0);
        end
        repeat (3) @(negedge sys_clk);
        send_byte2(8'h33, T2);
        send_byte2(8'h44, 1);
        checks++;
        if (te2_cnt - te0 !== 1 || busy2 !== 1'b1 || wd2 !== 32'h00001122) begin
            failures++;
            $display("FAIL tmo_one_late: got tes=%0d busy=%b wd=%h want 1 1 00001122", te2_cnt - te0, busy2, wd2);
        end
        send_byte2(8'h55, 1);
        checks++;
        if (wv2 !== 1'b1 || wd2 !== 32'h00004455) begin
            failures++;
            $display("FAIL tmo_after_restart: got wv=%b wd=%h want 1 00004455", wv2, wd2);
        end
        repeat (3) @(negedge sys_clk);
    endtask

    initial begin
        test_reset();
        test_basic_word();
        test_timeout();
        test_held_done();
        test_mid_word_reset();
        test_done_at_release();
        test_back_to_back();
        test_two_byte_word();
        test_timeout_boundary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
